mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/arb_starve_cnt.sv | 52 +++++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM encoding and
// default geometry.
package mem_arb_pkg;

  localparam int unsigned DefAddrW     = 32;
  localparam int unsigned DefDataW     = 32;
  localparam int unsigned DefStarveMax = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StServeI = 2'd1,
    StServeD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Winner selection between fetch and load/store requests, with a saturating
// counter that bounds how many data grants may overtake a waiting fetch.
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned StarveMax = DefStarveMax
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic grant_en_i,
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic i_block_i,
  input  logic d_block_i,
  output logic grant_i_o,
  output logic grant_d_o
);

  localparam int unsigned CntW = $clog2(StarveMax + 2);
  localparam logic [CntW-1:0] CntMax = CntW'(StarveMax);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pick_i, pick_d;

  always_comb begin
    pick_i = i_req_i & (~d_req_i | (cnt_q == CntMax));
    pick_d = d_req_i & ~pick_i;
    // A blocked winner (its ack is in flight) means nobody is granted this cycle.
    grant_i_o = grant_en_i & pick_i & ~i_block_i;
    grant_d_o = grant_en_i & pick_d & ~d_block_i;

    cnt_d = cnt_q;
    if (grant_i_o) begin
      cnt_d = '0;
    end else if (grant_d_o) begin
      if (!i_req_i) begin
        cnt_d = '0;
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single memory port. All outputs
// are registered; one access is outstanding at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned STARVE_MAX = DefStarveMax
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              busy_q, busy_d;
  logic              grant_i, grant_d;

  arb_starve_cnt #(
    .StarveMax (STARVE_MAX)
  ) u_starve_cnt (
    .clk_i      (clk),
    .reset_i    (reset),
    .grant_en_i (state_q == StIdle),
    .i_req_i    (i_req),
    .d_req_i    (d_req),
    .i_block_i  (i_ack_q),
    .d_block_i  (d_ack_q),
    .grant_i_o  (grant_i),
    .grant_d_o  (grant_d)
  );

  always_comb begin
    state_d   = state_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_i) begin
          state_d   = StServeI;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
        end else if (grant_d) begin
          state_d   = StServeD;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
        end
      end
      StServeI: begin
        if (m_ready) begin
          i_rdata_d = m_rdata;
          i_ack_d   = 1'b1;
          m_req_d   = 1'b0;
          state_d   = StIdle;
        end
      end
      StServeD: begin
        if (m_ready) begin
          // Stores complete the same way but leave the load data untouched.
          if (!m_we_q) begin
            d_rdata_d = m_rdata;
          end
          d_ack_d = 1'b1;
          m_req_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        m_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SM = 4;

  logic          clk;
  logic          reset;
  logic          i_req, d_req, d_we, m_ready;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, m_rdata;
  logic [DW-1:0] i_rdata, d_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic          i_ack, d_ack, m_req, m_we, busy;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SM)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({m_req, m_we, i_ack, d_ack, busy, m_addr, m_wdata, i_rdata, d_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_values: got req=%b we=%b iack=%b dack=%b busy=%b addr=%h wd=%h ird=%h drd=%h want all zero",
               m_req, m_we, i_ack, d_ack, busy, m_addr, m_wdata, i_rdata, d_rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle_ready();
    m_ready = 1'b1;
    m_rdata = 32'h1234_5678;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({i_ack, d_ack, busy, m_req} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_ready c%0d: got iack=%b dack=%b busy=%b mreq=%b want 0000",
                 c, i_ack, d_ack, busy, m_req);
      end
    end
    m_ready = 1'b0;
  endtask

  task automatic test_single_fetch();
    i_req   = 1'b1;
    i_addr  = 32'h100;
    m_ready = 1'b1;
    m_rdata = 32'h0050_0093;
    tick();
    checks++;
    if ({m_req, m_we, busy, i_ack} !== 4'b1010 || m_addr !== 32'h100) begin
      errors++;
      $display("FAIL fetch_cycle1: got mreq=%b we=%b busy=%b iack=%b addr=%h want 1,0,1,0 addr 100",
               m_req, m_we, busy, i_ack, m_addr);
    end
    tick();
    checks++;
    if (i_ack !== 1'b1 || d_ack !== 1'b0 || i_rdata !== 32'h0050_0093) begin
      errors++;
      $display("FAIL fetch_cycle2: got iack=%b dack=%b rdata=%h want 1 0 00500093",
               i_ack, d_ack, i_rdata);
    end
    i_req = 1'b0;
    tick();
    checks++;
    if (i_ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fetch_after: got iack=%b busy=%b want 0 0", i_ack, busy);
    end
  endtask

  task automatic test_simultaneous();
    i_req   = 1'b1;
    i_addr  = 32'h8;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h40;
    m_ready = 1'b1;
    m_rdata = 32'hD0D0_0040;
    tick();
    checks++;
    if (m_req !== 1'b1 || m_addr !== 32'h40) begin
      errors++;
      $display("FAIL simul_c1: got mreq=%b addr=%h want 1 40", m_req, m_addr);
    end
    tick();
    checks++;
    if (d_ack !== 1'b1 || i_ack !== 1'b0 || d_rdata !== 32'hD0D0_0040) begin
      errors++;
      $display("FAIL simul_c2: got dack=%b iack=%b drdata=%h want 1 0 d0d00040",
               d_ack, i_ack, d_rdata);
    end
    d_req   = 1'b0;
    m_rdata = 32'h1F1F_0008;
    tick();
    checks++;
    if (m_req !== 1'b1 || m_addr !== 32'h8 || d_ack !== 1'b0) begin
      errors++;
      $display("FAIL simul_c3: got mreq=%b addr=%h dack=%b want 1 8 0", m_req, m_addr, d_ack);
    end
    tick();
    checks++;
    if (i_ack !== 1'b1 || d_ack !== 1'b0 || i_rdata !== 32'h1F1F_0008) begin
      errors++;
      $display("FAIL simul_c4: got iack=%b dack=%b irdata=%h want 1 0 1f1f0008",
               i_ack, d_ack, i_rdata);
    end
    i_req = 1'b0;
    tick();
  endtask

  // Both requesters hold their requests: every (STARVE_MAX+1)th grant must go to the fetch.
  task automatic test_starvation();
    logic [AW-1:0] gaddr[$];
    logic          prev_mreq;
    logic [AW-1:0] exp_addr;
    i_req     = 1'b1;
    i_addr    = 32'h200;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h300;
    m_ready   = 1'b1;
    m_rdata   = 32'h57A2_0000;
    prev_mreq = m_req;
    for (int c = 0; c < 80 && gaddr.size() < 10; c++) begin
      tick();
      if (m_req && !prev_mreq) gaddr.push_back(m_addr);
      prev_mreq = m_req;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (gaddr.size() != 10) begin
      errors++;
      $display("FAIL starve_count: got %0d grants want 10", gaddr.size());
    end
    for (int k = 0; k < gaddr.size(); k++) begin
      exp_addr = (k % (SM + 1) == SM) ? 32'h200 : 32'h300;
      checks++;
      if (gaddr[k] !== exp_addr) begin
        errors++;
        $display("FAIL starve_grant%0d: got addr %h want %h", k, gaddr[k], exp_addr);
      end
    end
  endtask

  task automatic test_store_wait();
    int acks;
    acks    = 0;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h20;
    d_wdata = 32'hDEAD_BEEF;
    m_ready = 1'b0;
    m_rdata = 32'h1234_5678;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if ({m_req, m_we, d_ack} !== 3'b110 || m_wdata !== 32'hDEAD_BEEF || m_addr !== 32'h20) begin
        errors++;
        $display("FAIL store_hold%0d: got mreq=%b we=%b dack=%b wd=%h addr=%h want 1 1 0 deadbeef 20",
                 k, m_req, m_we, d_ack, m_wdata, m_addr);
      end
      if (k == 4) m_ready = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (d_ack) acks++;
      if (k == 0) begin
        checks++;
        if (d_ack !== 1'b1 || d_rdata !== 32'h57A2_0000) begin
          errors++;
          $display("FAIL store_ack: got dack=%b drdata=%h want 1 57a20000", d_ack, d_rdata);
        end
        d_req   = 1'b0;
        m_ready = 1'b0;
      end
    end
    checks++;
    if (acks != 1) begin
      errors++;
      $display("FAIL store_ack_count: got %0d want 1", acks);
    end
  endtask

  task automatic test_reset_mid_access();
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h44;
    m_ready = 1'b0;
    m_rdata = 32'hAAAA_5555;
    tick();
    checks++;
    if (m_req !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_serve: got mreq=%b busy=%b want 1 1", m_req, busy);
    end
    reset   = 1'b1;
    m_ready = 1'b1;
    tick();
    checks++;
    if ({m_req, m_we, i_ack, d_ack, busy, m_addr, m_wdata, i_rdata, d_rdata} !== '0) begin
      errors++;
      $display("FAIL rstmid_values: got req=%b dack=%b busy=%b addr=%h ird=%h drd=%h want all zero",
               m_req, d_ack, busy, m_addr, i_rdata, d_rdata);
    end
    reset   = 1'b0;
    d_req   = 1'b0;
    m_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({d_ack, m_req, busy} !== 3'b000) begin
        errors++;
        $display("FAIL rstmid_quiet%0d: got dack=%b mreq=%b busy=%b want 000", c, d_ack, m_req, busy);
      end
    end
  endtask

  // Reference model: who owns the memory port, how many data grants have
  // overtaken the fetch, and what each visible output should currently be.
  int            own;  // 0 none, 1 fetch, 2 data
  int            sc;
  logic          ei_ack, ed_ack, e_mreq, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_irdata, e_drdata;

  task automatic model_step();
    logic pi, pd;
    int   win;
    if (reset) begin
      own = 0; sc = 0; e_mreq = 0; e_we = 0; e_addr = '0; e_wdata = '0;
      ei_ack = 0; ed_ack = 0; e_irdata = '0; e_drdata = '0;
      return;
    end
    pi = ei_ack;
    pd = ed_ack;
    ei_ack = 0;
    ed_ack = 0;
    if (own != 0) begin
      if (m_ready) begin
        if (own == 1) begin
          e_irdata = m_rdata;
          ei_ack   = 1;
        end else begin
          if (!e_we) e_drdata = m_rdata;
          ed_ack = 1;
        end
        own    = 0;
        e_mreq = 0;
      end
    end else begin
      win = 0;
      if (i_req && d_req) win = (sc == SM) ? 1 : 2;
      else if (i_req) win = 1;
      else if (d_req) win = 2;
      if ((win == 1 && pi) || (win == 2 && pd)) win = 0;
      if (win == 1) begin
        own = 1; e_mreq = 1; e_we = 0; e_addr = i_addr; e_wdata = '0; sc = 0;
      end else if (win == 2) begin
        own = 2; e_mreq = 1; e_we = d_we; e_addr = d_addr; e_wdata = d_wdata;
        sc = i_req ? ((sc < SM) ? sc + 1 : SM) : 0;
      end
    end
  endtask

  task automatic test_random();
    reset   = 1'b1;
    i_req   = 1'b0;
    d_req   = 1'b0;
    m_ready = 1'b0;
    model_step();
    tick();
    reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (ei_ack || !i_req) begin
        i_req = ($urandom_range(0, 2) == 0);
        i_addr = {$urandom_range(0, 255), 2'b00};
      end
      if (ed_ack || !d_req) begin
        d_req   = ($urandom_range(0, 1) == 0);
        d_we    = $urandom_range(0, 1);
        d_addr  = {$urandom_range(0, 255), 2'b00};
        d_wdata = $urandom;
      end
      m_ready = $urandom_range(0, 1);
      m_rdata = $urandom;
      reset   = ($urandom_range(0, 199) == 0);
      model_step();
      tick();
      checks++;
      if ({m_req, busy, i_ack, d_ack} !== {e_mreq, own != 0, ei_ack, ed_ack}) begin
        errors++;
        $display("FAIL rand_ctl n=%0d: got mreq=%b busy=%b iack=%b dack=%b want %b %b %b %b",
                 n, m_req, busy, i_ack, d_ack, e_mreq, own != 0, ei_ack, ed_ack);
      end
      checks++;
      if (m_addr !== e_addr || m_we !== e_we) begin
        errors++;
        $display("FAIL rand_addr n=%0d: got addr=%h we=%b want %h %b", n, m_addr, m_we, e_addr, e_we);
      end
      if (e_mreq && e_we) begin
        checks++;
        if (m_wdata !== e_wdata) begin
          errors++;
          $display("FAIL rand_wdata n=%0d: got %h want %h", n, m_wdata, e_wdata);
        end
      end
      checks++;
      if (i_rdata !== e_irdata || d_rdata !== e_drdata) begin
        errors++;
        $display("FAIL rand_rdata n=%0d: got i=%h d=%h want i=%h d=%h",
                 n, i_rdata, d_rdata, e_irdata, e_drdata);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    i_req   = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    i_addr  = '0;
    d_addr  = '0;
    d_wdata = '0;
    m_rdata = '0;
    m_ready = 1'b0;
    test_reset();
    test_idle_ready();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_store_wait();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
